alu_nibble_sequencer: RTL and testbench
=======================================

Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs one 4-bit `alu` instance over WIDTH/4 nibbles, LSB nibble first, to do WIDTH-bit ALU operations.
- Per nibble it selects the operand nibbles, drives the 5-bit ALU control word with the carry_in bit overridden, and chains carry_out into the next nibble.
- Sits between an instruction decoder (start/op) and the register file (result/flags).

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; accepted only when busy=0.
- op  input  3  operation: 0 ADD, 1 SUB, 2 COMP, 3 XOR, 4 XNOR, 5 AND, 6 OR, 7 RSHFT.
- a  input  WIDTH  operand 1 (ALU d1); ignored by RSHFT.
- b  input  WIDTH  operand 2 (ALU d2).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result and flags updated.
- result  output  WIDTH  registered result.
- carry  output  1  registered carry/flag, defined per op below.
- zero  output  1  registered, 1 when result==0.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, carry=0, zero=0, nibble index=0, carry chain reg=0.
- States:
  - IDLE: on a clock edge with start=1, latch a, b and op, set idx=0, go to RUN, busy=1.
  - RUN: each clock edge, the ALU result for nibble idx is written to result[4*idx+3:4*idx] and ALU carry_out is stored in the chain reg.
    - If idx==NIBBLES-1: go to IDLE, busy=0, done=1 for exactly one cycle, update carry and zero.
    - Otherwise: idx+1.
- Latency: done rises on the NIBBLES-th edge after the accepting edge (4 for WIDTH=16). Throughput is one op per NIBBLES cycles; start may be high in the cycle done is high and is accepted then.
- start while busy=1 is ignored, not queued. Latched operands isolate a, b and op changes during RUN.
- result bits are overwritten nibble by nibble during RUN. They are valid only when busy=0 and hold until the next accepted op.
- Base ALU control words {carry_in, b_inv, carry_disable, cmd[1:0]}, x bits resolved to 0:
  - ADD 00000, SUB 11000, COMP 01000, XOR 00100, XNOR 01100, AND 00101, OR 00110, RSHFT 00111.
- Per-nibble carry_in:
  - ADD/SUB/COMP: nibble 0 uses base bit4 (ADD 0, SUB 1, COMP 0); later nibbles use the chain reg.
  - XOR/XNOR/AND/OR: 0.
  - RSHFT: b[4*(idx+1)] for idx<NIBBLES-1; 0 for the top nibble (logical shift right by 1).
- Final carry flag:
  - ADD: final carry_out (unsigned overflow).
  - SUB: final raw carry_out (1 = no borrow, a>=b).
  - COMP: final raw carry_out (for a!=b, 1 means a>b; a==b gives 0).
  - Logic ops: 0.
  - RSHFT: latched b[0] (the bit shifted out).
- zero is computed on the final nibble write from the complete WIDTH-bit result.
- Reset asserted mid-RUN aborts the op: all outputs return to reset values immediately, and there is no done pulse.

Test Plan:
- ADD a=0xFFFF b=0x0001 -> busy for 4 cycles, done pulse on 4th edge, result=0x0000, carry=1, zero=1.
- SUB a=0x1234 b=0x1235 -> result=0xFFFF, carry=0, zero=0. SUB a=0x1235 b=0x1234 -> result=0x0001, carry=1.
- COMP a=0x8000 b=0x7FFF -> carry=1. COMP a=0x7FFF b=0x8000 -> carry=0 (nibble carry must chain across all 4 nibbles).
- RSHFT b=0x8421 a=0xFFFF -> result=0x4210, carry=1. XNOR a=0x0000 b=0x00F0 -> result=0xFF0F, carry=0.
- Start pulsed in cycles 2 and 3 of a running ADD with different a/b -> ignored, first result unchanged. Start in the done cycle -> accepted, busy stays 1.
- rst asserted on 2nd RUN cycle of an ADD -> busy=0, done=0, result=0 asynchronously. The next ADD 0x0F0F+0x00F1 -> result=0x1000, carry=0.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// alu_nibble_sequencer
//
// Runs WIDTH-bit ALU operations on a single 4-bit ALU, one nibble per clock,
// least significant nibble first. Operands and opcode are captured when an
// operation is accepted. Each RUN cycle computes one nibble. The carry out of
// that nibble is kept in a chain register for the next nibble. After the last
// nibble the carry and zero flags are updated and done pulses for one cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   start_i   operation request, accepted only while busy_o = 0
//   op_i      0 ADD, 1 SUB, 2 COMP, 3 XOR, 4 XNOR, 5 AND, 6 OR, 7 RSHFT
//   a_i       operand 1 (ALU d1); not used by RSHFT
//   b_i       operand 2 (ALU d2)
//   busy_o    high while an operation is in progress
//   done_o    one-cycle pulse when result_o / carry_o / zero_o are updated
//   result_o  registered result; valid while busy_o = 0
//   carry_o   registered carry / comparison / shifted-out flag
//   zero_o    registered, high when the final result is zero
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu: 4-bit combinational ALU slice.
//   ctrl_i = {carry_in, b_inv, carry_disable, cmd[1:0]}
//   carry_disable = 0 : d1 + (b_inv ? ~d2 : d2) + carry_in
//   carry_disable = 1 : cmd 00 XOR, 01 AND, 10 OR, 11 shift d2 right by one
//                       with carry_in entering the MSB. The bit shifted out
//                       leaves on carry_o.
//   Ports: d1_i, d2_i (4-bit operands), ctrl_i (5-bit control),
//          result_o (4-bit), carry_o.
// ---------------------------------------------------------------------------
module alu (
  input  logic [3:0] d1_i,
  input  logic [3:0] d2_i,
  input  logic [4:0] ctrl_i,
  output logic [3:0] result_o,
  output logic       carry_o
);

  logic       carry_in;
  logic       b_inv;
  logic       carry_disable;
  logic [1:0] cmd;
  logic [3:0] d2_x;
  logic [4:0] sum;

  assign carry_in      = ctrl_i[4];
  assign b_inv         = ctrl_i[3];
  assign carry_disable = ctrl_i[2];
  assign cmd           = ctrl_i[1:0];
  assign d2_x          = b_inv ? ~d2_i : d2_i;
  assign sum           = 5'(d1_i) + 5'(d2_x) + 5'(carry_in);

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the case statement can leave a value held (latch).
  always_comb begin
    result_o = 4'h0;
    carry_o  = 1'b0;
    if (!carry_disable) begin
      result_o = sum[3:0];
      carry_o  = sum[4];
    end else begin
      unique case (cmd)
        2'b00: result_o = d1_i ^ d2_x;
        2'b01: result_o = d1_i & d2_x;
        2'b10: result_o = d1_i | d2_x;
        2'b11: begin
          result_o = {carry_in, d2_x[3:1]};
          carry_o  = d2_x[0];
        end
        default: result_o = 4'h0;
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// alu_nibble_sequencer: top level
// ---------------------------------------------------------------------------
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_COMP  = 3'd2,
    OP_XOR   = 3'd3,
    OP_XNOR  = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_RSHFT = 3'd7
  } op_e;

  // Base control word {carry_in, b_inv, carry_disable, cmd}. Bit 4 is only
  // the nibble-0 carry_in for the arithmetic ops. The per-nibble value
  // replaces it before the word reaches the ALU.
  function automatic logic [4:0] base_ctrl(input op_e op);
    logic [4:0] w;
    unique case (op)
      OP_ADD:   w = 5'b00000;
      OP_SUB:   w = 5'b11000;
      OP_COMP:  w = 5'b01000;
      OP_XOR:   w = 5'b00100;
      OP_XNOR:  w = 5'b01100;
      OP_AND:   w = 5'b00101;
      OP_OR:    w = 5'b00110;
      OP_RSHFT: w = 5'b00111;
      default:  w = 5'b00000;
    endcase
    return w;
  endfunction

  state_e           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  op_e              op_q,     op_d;
  logic             chain_q,  chain_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;

  // Operand slice for the current nibble, and the ALU hookup.
  logic [3:0]   a_nib;
  logic [3:0]   b_nib;
  logic         rsh_cin;
  logic         nib_cin;
  logic [4:0]   base_w;
  logic [4:0]   alu_ctrl;
  logic [3:0]   alu_res;
  logic         alu_co;
  logic [WIDTH:0] b_ext;

  // b_ext has a zero above the MSB. The shift-in bit for the top nibble is
  // then 0, which makes RSHFT a logical shift.
  assign b_ext = {1'b0, b_q};

  always_comb begin
    a_nib   = 4'h0;
    b_nib   = 4'h0;
    rsh_cin = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib   = a_q[4*n +: 4];
        b_nib   = b_q[4*n +: 4];
        rsh_cin = b_ext[4*n + 4];
      end
    end
  end

  assign base_w = base_ctrl(op_q);

  always_comb begin
    nib_cin = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB, OP_COMP: nib_cin = (idx_q == '0) ? base_w[4] : chain_q;
      OP_RSHFT:                nib_cin = rsh_cin;
      default:                 nib_cin = 1'b0;
    endcase
  end

  assign alu_ctrl = {nib_cin, base_w[3:0]};

  alu u_alu (
    .d1_i     (a_nib),
    .d2_i     (b_nib),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_res),
    .carry_o  (alu_co)
  );

  // Result with the current nibble merged in. zero is taken from this value
  // so the flag sees the final nibble in the same cycle it is written.
  logic [WIDTH-1:0] result_wr;
  logic             final_carry;

  always_comb begin
    result_wr = result_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        result_wr[4*n +: 4] = alu_res;
      end
    end
  end

  always_comb begin
    final_carry = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB, OP_COMP: final_carry = alu_co;
      OP_RSHFT:                final_carry = b_q[0];
      default:                 final_carry = 1'b0;
    endcase
  end

  // Next-state and data-path update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    chain_d  = chain_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_e'(op_i);
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        result_d = result_wr;
        chain_d  = alu_co;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          carry_d = final_carry;
          zero_d  = ~|result_wr;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      chain_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_nibble_sequencer
//
// Directed-vector bench for alu_nibble_sequencer (WIDTH = 16). Expected
// results are hand-computed constants. The input bus is scrambled after each
// accepting edge, so the result must come from the captured operands.
// ---------------------------------------------------------------------------
module tb_alu_nibble_sequencer;

  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] COMP  = 3'd2;
  localparam logic [2:0] XOR_  = 3'd3;
  localparam logic [2:0] XNOR_ = 3'd4;
  localparam logic [2:0] AND_  = 3'd5;
  localparam logic [2:0] OR_   = 3'd6;
  localparam logic [2:0] RSHFT = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .carry_o  (carry),
    .zero_o   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done !== 1'b1 && cyc < 20);
    check({tag, ".latency"}, 32'(cyc), 32'd4);
  endtask

  // Issues one op, scrambles the inputs, and returns during the done cycle.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec,
                        input logic ez);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 3'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(tag);
    check({tag, ".busy_at_done"}, 32'(busy),   32'd0);
    check({tag, ".result"},       32'(result), 32'(er));
    check({tag, ".carry"},        32'(carry),  32'(ec));
    check({tag, ".zero"},         32'(zero),   32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 16'h0;
    b     = 16'h0;
    #12;
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.carry",  32'(carry),  32'd0);
    check("reset.zero",   32'(zero),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op("add_wrap",   ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    tick();
    check("add_wrap.done_pulse", 32'(done), 32'd0);

    run_op("sub_borrow", SUB,   16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0);
    run_op("sub_nobor",  SUB,   16'h1235, 16'h1234, 16'h0001, 1'b1, 1'b0);
    run_op("comp_gt",    COMP,  16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    run_op("comp_lt",    COMP,  16'h7FFF, 16'h8000, 16'hFFFE, 1'b0, 1'b0);
    run_op("comp_eq",    COMP,  16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0);
    run_op("rshft",      RSHFT, 16'hFFFF, 16'h8421, 16'h4210, 1'b1, 1'b0);
    run_op("rshft_lo",   RSHFT, 16'h0000, 16'h0002, 16'h0001, 1'b0, 1'b0);
    run_op("xnor",       XNOR_, 16'h0000, 16'h00F0, 16'hFF0F, 1'b0, 1'b0);
    run_op("xor",        XOR_,  16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0);
    run_op("and",        AND_,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
    run_op("or",         OR_,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    run_op("add_chain",  ADD,   16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
    tick();

    // Start requests during RUN cycles 2 and 3 must be ignored.
    op    = ADD;
    a     = 16'h1111;
    b     = 16'h0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    tick();
    tick();
    start = 1'b0;
    tick();
    check("ignore.done",   32'(done),   32'd1);
    check("ignore.result", 32'(result), 32'h1212);
    check("ignore.carry",  32'(carry),  32'd0);
    tick();
    check("ignore.no_restart", 32'(busy), 32'd0);
    check("ignore.done_low",   32'(done), 32'd0);

    // A start in the done cycle is accepted on the next edge.
    run_op("bb_first", ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
    check("bb.done_cycle", 32'(done), 32'd1);
    run_op("bb_second", SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    tick();

    // Reset during the 2nd RUN cycle aborts the operation.
    op    = ADD;
    a     = 16'h1111;
    b     = 16'h2222;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort.nibble0", 32'(result), 32'h0003);
    check("abort.busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort.busy",   32'(busy),   32'd0);
    check("abort.done",   32'(done),   32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.carry",  32'(carry),  32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort.quiet", 32'(seen), 32'd0);

    run_op("post_rst", ADD, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
